// File: rtl/intensity_grid.sv
// -----------------------------------------------------------------------------
// intensity_grid
//
// Converts a 3x3 window of 24-bit RGB pixels into a 3x3 grid of 8-bit
// intensity values for the cartoonifier edge-detection path. It sits between
// the pixel-window buffer and the edge-detect stage.
//
// Each intensity is (R>>2) + (G>>1) + (B>>2). All nine lanes are computed in
// parallel and loaded together into a single output register on
// intensity_enable. The grid holds its value otherwise.
//
// Ports
//   clk                in   1    system clock, rising-edge active
//   n_rst              in   1    synchronous active-low reset
//   pixelData          in   216  nine RGB pixels P0..P8; Pk at [215-24k -: 24],
//                                R = [23:16], G = [15:8], B = [7:0] of the slice
//   intensity_enable   in   1    load strobe; recompute and load the grid
//   edgedetect_enable  in   1    downstream status, reserved and ignored
//   iGrid              out  72   nine intensities I0..I8; Ik at [71-8k -: 8]
// -----------------------------------------------------------------------------
module intensity_grid (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [215:0] pixelData,
    input  logic         intensity_enable,
    input  logic         edgedetect_enable,
    output logic [71:0]  iGrid
);

    localparam int unsigned NUM_PIXELS = 9;
    localparam int unsigned PIXEL_W    = 24;
    localparam int unsigned INT_W      = 8;

    // One pixel's intensity. The three shifted terms are each zero-extended
    // to 8 bits; the largest possible sum is 63 + 127 + 63 = 253, so the
    // 8-bit add can never wrap.
    function automatic logic [INT_W-1:0] rgb_to_intensity(
        input logic [PIXEL_W-1:0] pixel
    );
        logic [INT_W-1:0] r_term;
        logic [INT_W-1:0] g_term;
        logic [INT_W-1:0] b_term;
        r_term = {2'b00, pixel[23:18]};
        g_term = {1'b0,  pixel[15:9]};
        b_term = {2'b00, pixel[7:2]};
        return r_term + g_term + b_term;
    endfunction

    // Nine independent lanes; lane k reads pixel k and writes intensity k,
    // both counted from the MSB end of their buses.
    logic [71:0] grid_next;

    for (genvar k = 0; k < NUM_PIXELS; k++) begin : g_lane
        assign grid_next[71-INT_W*k -: INT_W] =
            rgb_to_intensity(pixelData[215-PIXEL_W*k -: PIXEL_W]);
    end

    // Output register: reset has priority over load, load over hold.
    // NOTE: state is updated with non-blocking assignments so every reader
    // sees the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            iGrid <= '0;
        end else if (intensity_enable) begin
            iGrid <= grid_next;
        end
    end

    // The downstream status input is reserved and deliberately unused.
    logic unused_edgedetect;
    assign unused_edgedetect = edgedetect_enable;

endmodule

// File: tb/tb_intensity_grid.sv
// -----------------------------------------------------------------------------
// tb_intensity_grid
//
// Self-checking bench for intensity_grid. A reference model computes each
// intensity with plain integer arithmetic (R/4 + G/2 + B/4) and tracks the
// expected register contents cycle by cycle.
// -----------------------------------------------------------------------------
module tb_intensity_grid;

    logic         tb_clk;
    logic         n_rst;
    logic [215:0] pixelData;
    logic         intensity_enable;
    logic         edgedetect_enable;
    logic [71:0]  iGrid;

    int n_checks;
    int n_errors;

    logic [71:0] exp_grid;

    intensity_grid dut (
        .clk               (tb_clk),
        .n_rst             (n_rst),
        .pixelData         (pixelData),
        .intensity_enable  (intensity_enable),
        .edgedetect_enable (edgedetect_enable),
        .iGrid             (iGrid)
    );

    initial tb_clk = 1'b0;
    always #10 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] px(input int r, input int g, input int b);
        logic [7:0] r8, g8, b8;
        r8 = 8'(r);
        g8 = 8'(g);
        b8 = 8'(b);
        return {r8, g8, b8};
    endfunction

    // Reference: integer division on each channel, one byte per pixel.
    function automatic logic [71:0] ref_grid(input logic [215:0] pd);
        logic [71:0] out;
        logic [23:0] p;
        int          val;
        out = '0;
        for (int k = 0; k < 9; k++) begin
            p   = pd[215-24*k -: 24];
            val = int'(p[23:16]) / 4 + int'(p[15:8]) / 2 + int'(p[7:0]) / 4;
            out[71-8*k -: 8] = 8'(val);
        end
        return out;
    endfunction

    // Advance one clock; the model follows the register rules at the edge.
    task automatic tick();
        @(posedge tb_clk);
        if (!n_rst)
            exp_grid = '0;
        else if (intensity_enable)
            exp_grid = ref_grid(pixelData);
        #1;
    endtask

    logic [71:0] tri_a, tri_b, tri_c;
    logic [71:0] snap;

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_grid = '0;

        tri_a = {px(20, 20, 40),  px(60, 80, 100), px(120, 144, 160)};
        tri_b = {px(12, 24, 48),  px(60, 72, 84),  px(96, 155, 189)};
        tri_c = {px(5, 22, 42),   px(65, 99, 100), px(210, 200, 164)};

        // Reset with enable high and arbitrary pixels.
        n_rst             = 1'b0;
        intensity_enable  = 1'b1;
        edgedetect_enable = 1'b0;
        pixelData         = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom};
        tick();
        check("reset", iGrid, 72'h0);

        // Releasing reset between edges changes nothing until the next edge,
        // and pixel changes mid-cycle never reach the output directly.
        n_rst     = 1'b1;
        #4;
        pixelData = {tri_c, tri_c, tri_c};
        #2;
        check("no_comb_path", iGrid, 72'h0);

        // Single load {A,C,B}, then enable low.
        pixelData        = {tri_a, tri_c, tri_b};
        intensity_enable = 1'b1;
        tick();
        check("single_load", iGrid, exp_grid);
        check("single_load_ref", iGrid, {8'd25, 8'd80, 8'd142,
                                         8'd22, 8'd90, 8'd193,
                                         8'd27, 8'd72, 8'd148});
        intensity_enable = 1'b0;
        tick();
        check("single_load_after", iGrid, exp_grid);

        // Load {C,A,B}, then hold for three cycles with {B,A,C} applied.
        pixelData        = {tri_c, tri_a, tri_b};
        intensity_enable = 1'b1;
        tick();
        check("hold_load", iGrid, exp_grid);
        intensity_enable = 1'b0;
        pixelData        = {tri_b, tri_a, tri_c};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", iGrid, exp_grid);
        end

        // Back-to-back loads.
        intensity_enable = 1'b1;
        pixelData        = {tri_a, tri_b, tri_c};
        tick();
        check("b2b_first", iGrid, exp_grid);
        pixelData        = {tri_b, tri_c, tri_a};
        tick();
        check("b2b_second", iGrid, exp_grid);

        // Enable held with constant pixels: stable output.
        snap = iGrid;
        tick();
        check("enable_const", iGrid, snap);

        // Bounds.
        pixelData = {216{1'b1}};
        tick();
        check("bound_ff", iGrid, {9{8'd253}});
        pixelData = {72{3'b000}} | {27{8'h03}};
        tick();
        check("bound_03", iGrid, {9{8'd1}});
        pixelData = '0;
        tick();
        check("bound_00", iGrid, {9{8'd0}});

        // Reset and enable together: reset wins.
        pixelData = {tri_a, tri_a, tri_a};
        tick();
        check("pre_reset_load", iGrid, exp_grid);
        n_rst = 1'b0;
        tick();
        check("reset_over_enable", iGrid, 72'h0);
        n_rst = 1'b1;

        // Random traffic with edgedetect_enable toggling; the model ignores it.
        for (int i = 0; i < 300; i++) begin
            pixelData         = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom};
            intensity_enable  = 1'($urandom_range(0, 1));
            edgedetect_enable = 1'($urandom_range(0, 1));
            n_rst             = ($urandom_range(0, 19) != 0);
            tick();
            check("random", iGrid, exp_grid);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
